// File: rtl/program_loader_pkg.sv
// Shared types and sizes for the program loader.
package program_loader_pkg;

    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StCsum,
        StHold,
        StRun,
        StErr
    } state_e;

endpackage

// File: rtl/loader_checksum.sv
// Mod-2^Width running sum with clear/add and a "sum plus this byte is zero" check.
module loader_checksum #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             add_i,
    input  logic [Width-1:0] data_i,
    output logic             zero_o
);

    logic [Width-1:0] acc_d, acc_q, sum;

    // Next accumulator value; clear takes priority over add.
    always_comb begin
        sum   = acc_q + data_i;
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = sum;
        end
    end

    assign zero_o = (sum == '0);

    // Accumulator register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a length/payload/checksum frame into the instruction memory, then
// releases the control unit reset after a short hold.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned RELEASE_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_write,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   load_count
);

    localparam int unsigned HoldW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(RELEASE_CYCLES - 1);

    state_e            state_d, state_q;
    logic [ADDR_W:0]   len_d, len_q;
    logic [ADDR_W:0]   count_d, count_q;
    logic [HoldW-1:0]  hold_d, hold_q;
    logic              mem_write_d, mem_write_q;
    logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
    logic [DATA_W-1:0] mem_data_d, mem_data_q;

    logic xfer;
    logic len_bad;
    logic csum_clear, csum_add, csum_zero;

    assign xfer    = in_valid & in_ready;
    assign len_bad = (in_data == '0) || (in_data > DATA_W'(MEM_DEPTH));

    loader_checksum #(
        .Width (DATA_W)
    ) u_checksum (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clear_i (csum_clear),
        .add_i   (csum_add),
        .data_i  (in_data),
        .zero_o  (csum_zero)
    );

    // Frame FSM: next state, counters and state-decoded outputs.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        count_d    = count_q;
        hold_d     = hold_q;
        csum_clear = 1'b0;
        csum_add   = 1'b0;
        in_ready   = 1'b0;
        cpu_reset  = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StLen;
                    count_d    = '0;
                    csum_clear = 1'b1;
                end
            end
            StLen: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) begin
                    if (len_bad) begin
                        state_d = StErr;
                    end else begin
                        len_d   = in_data[ADDR_W:0];
                        state_d = StData;
                    end
                end
            end
            StData: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) begin
                    count_d  = count_q + 1'b1;
                    csum_add = 1'b1;
                    if (count_d == len_q) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) begin
                    if (csum_zero) begin
                        state_d = StHold;
                        hold_d  = '0;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StHold: begin
                busy = 1'b1;
                if (hold_q == HoldLast) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StRun: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
                if (start) begin
                    state_d    = StLen;
                    count_d    = '0;
                    csum_clear = 1'b1;
                end
            end
            StErr: begin
                error = 1'b1;
                if (start) begin
                    state_d    = StLen;
                    count_d    = '0;
                    csum_clear = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Memory write port: words written so far doubles as the write index.
    always_comb begin
        mem_write_d = (state_q == StData) && xfer;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        if (mem_write_d) begin
            mem_addr_d = count_q[ADDR_W-1:0];
            mem_data_d = in_data;
        end
    end

    // State, counter and write-port registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            len_q       <= '0;
            count_q     <= '0;
            hold_q      <= '0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            hold_q      <= hold_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign mem_write   = mem_write_q;
    assign mem_address = mem_addr_q;
    assign mem_data    = mem_data_q;
    assign load_count  = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized and directed bench for program_loader against a frame-level model.
module tb_program_loader;

    localparam int unsigned RELEASE = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [3:0] mem_address;
    logic [7:0] mem_data;
    logic       mem_write;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       error;
    logic [4:0] load_count;

    program_loader #(
        .RELEASE_CYCLES (RELEASE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_write   (mem_write),
        .cpu_reset   (cpu_reset),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .load_count  (load_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Frame-level model: byte position within the frame, running sum, hold countdown.
    bit m_loading;
    int m_pos, m_len, m_sum, m_hold, m_count;
    bit m_done, m_err, m_wr;
    int m_wa, m_wd;

    logic [3:0] wa_log[$];
    logic [7:0] wd_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_loading = 0; m_pos = 0; m_len = 0; m_sum = 0; m_hold = 0; m_count = 0;
        m_done = 0; m_err = 0; m_wr = 0; m_wa = 0; m_wd = 0;
    endfunction

    function automatic void model_step(input bit st, input bit vld, input int d);
        bit frame_busy;
        frame_busy = m_loading || (m_hold > 0);
        m_wr = 0;
        if (st && !frame_busy) begin
            m_loading = 1; m_pos = 0; m_sum = 0; m_count = 0; m_done = 0; m_err = 0;
        end else if (vld && m_loading) begin
            if (m_pos == 0) begin
                if (d == 0 || d > 16) begin
                    m_loading = 0;
                    m_err     = 1;
                end else begin
                    m_len = d;
                    m_pos = 1;
                end
            end else if (m_pos <= m_len) begin
                m_wr = 1; m_wa = m_pos - 1; m_wd = d;
                m_count++;
                m_sum = (m_sum + d) % 256;
                m_pos++;
            end else begin
                m_loading = 0;
                if ((m_sum + d) % 256 == 0) m_hold = RELEASE;
                else m_err = 1;
            end
        end else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) m_done = 1;
        end
    endfunction

    // Model advances on the same edge the DUT samples.
    always @(posedge clock or negedge reset) begin
        if (!reset) model_clear();
        else model_step(start, in_valid, int'(in_data));
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clock) begin
        if (reset && cmp_en) begin
            chk("in_ready",   32'(in_ready),   32'(m_loading));
            chk("busy",       32'(busy),       32'(m_loading || (m_hold > 0)));
            chk("cpu_reset",  32'(cpu_reset),  32'(!m_done));
            chk("done",       32'(done),       32'(m_done));
            chk("error",      32'(error),      32'(m_err));
            chk("load_count", 32'(load_count), 32'(m_count));
            chk("mem_write",  32'(mem_write),  32'(m_wr));
            if (m_wr) begin
                chk("mem_address", 32'(mem_address), 32'(m_wa));
                chk("mem_data",    32'(mem_data),    32'(m_wd));
            end
        end
        if (reset && mem_write === 1'b1) begin
            wa_log.push_back(mem_address);
            wd_log.push_back(mem_data);
        end
    end

    task automatic check_reset_values();
        chk("rst_in_ready",    32'(in_ready),    32'(0));
        chk("rst_mem_write",   32'(mem_write),   32'(0));
        chk("rst_mem_address", 32'(mem_address), 32'(0));
        chk("rst_mem_data",    32'(mem_data),    32'(0));
        chk("rst_cpu_reset",   32'(cpu_reset),   32'(1));
        chk("rst_busy",        32'(busy),        32'(0));
        chk("rst_done",        32'(done),        32'(0));
        chk("rst_error",       32'(error),       32'(0));
        chk("rst_load_count",  32'(load_count),  32'(0));
    endtask

    // Pulse start (possibly with a stray valid byte), then stream bytes.
    // mode 0: valid every cycle, 3: every third cycle, other: random.
    task automatic send_frame(input logic [7:0] bytes[$], input int mode, input bit mid_start);
        int tries;
        bit acc;
        @(negedge clock);
        start    = 1'b1;
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
        @(negedge clock);
        start = 1'b0;
        foreach (bytes[i]) begin
            acc   = 1'b0;
            tries = 0;
            while (!acc) begin
                if (!m_loading) begin
                    in_valid = 1'b0;
                    start    = 1'b0;
                    return;
                end
                if (tries > 200) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL accept_bound: byte %0d not accepted after %0d cycles", i, tries);
                    in_valid = 1'b0;
                    start    = 1'b0;
                    return;
                end
                in_data = bytes[i];
                case (mode)
                    0:       in_valid = 1'b1;
                    3:       in_valid = 1'((tries % 3) == 2);
                    default: in_valid = 1'($urandom_range(0, 1));
                endcase
                start = 1'(mid_start && ($urandom_range(0, 3) == 0));
                acc   = in_valid && m_loading;
                tries++;
                @(negedge clock);
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while ((m_loading || m_hold > 0) && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (n >= 60) begin
            n_checks++;
            n_fail++;
            $display("FAIL quiet_bound: frame still active after %0d cycles", n);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fr[$];
        logic [7:0] b;
        logic [7:0] csum;
        int n, sum, kind, mode, rel;

        model_clear();
        #1;
        check_reset_values();
        #21;
        reset  = 1'b1;
        cmp_en = 1'b1;

        // 1: basic three-word frame
        wa_log.delete(); wd_log.delete();
        fr = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
        send_frame(fr, 0, 1'b0);
        rel = 0;
        while (cpu_reset && rel < 20) begin
            @(negedge clock);
            rel++;
        end
        chk("t1_release_delay", 32'(rel), 32'(4));
        chk("t1_done", 32'(done), 32'(1));
        chk("t1_load_count", 32'(load_count), 32'(3));
        chk("t1_nwrites", 32'(wa_log.size()), 32'(3));
        for (int i = 0; i < 3; i++) begin
            if (i < wa_log.size()) begin
                chk("t1_addr", 32'(wa_log[i]), 32'(i));
                chk("t1_data", 32'(wd_log[i]), 32'(8'h11 * (i + 1)));
            end
        end

        // 2: bad checksum
        wa_log.delete(); wd_log.delete();
        fr = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h9B};
        send_frame(fr, 0, 1'b0);
        wait_quiet();
        idle_cycles(3);
        chk("t2_nwrites", 32'(wa_log.size()), 32'(3));
        chk("t2_error", 32'(error), 32'(1));
        chk("t2_done", 32'(done), 32'(0));
        chk("t2_cpu_reset", 32'(cpu_reset), 32'(1));

        // 3: bad lengths
        wa_log.delete(); wd_log.delete();
        fr = '{8'h00};
        send_frame(fr, 0, 1'b0);
        chk("t3a_error", 32'(error), 32'(1));
        fr = '{8'h11};
        send_frame(fr, 0, 1'b0);
        chk("t3b_error", 32'(error), 32'(1));
        idle_cycles(2);
        chk("t3_nwrites", 32'(wa_log.size()), 32'(0));

        // 4: full 16-word frame
        wa_log.delete(); wd_log.delete();
        fr.delete();
        fr.push_back(8'h10);
        for (int i = 0; i < 16; i++) fr.push_back(8'(i));
        fr.push_back(8'h88);
        send_frame(fr, 0, 1'b0);
        wait_quiet();
        chk("t4_done", 32'(done), 32'(1));
        chk("t4_load_count", 32'(load_count), 32'(16));
        chk("t4_nwrites", 32'(wa_log.size()), 32'(16));
        for (int i = 0; i < 16; i++) begin
            if (i < wa_log.size()) begin
                chk("t4_addr", 32'(wa_log[i]), 32'(i));
                chk("t4_data", 32'(wd_log[i]), 32'(i));
            end
        end

        // 5: gapped valid with stray start pulses
        wa_log.delete(); wd_log.delete();
        fr = '{8'h04, 8'hA0, 8'h05, 8'h3C, 8'hFF, 8'h20};
        send_frame(fr, 3, 1'b1);
        wait_quiet();
        chk("t5_done", 32'(done), 32'(1));
        chk("t5_nwrites", 32'(wa_log.size()), 32'(4));
        if (wa_log.size() == 4) begin
            chk("t5_d0", 32'(wd_log[0]), 32'(8'hA0));
            chk("t5_d1", 32'(wd_log[1]), 32'(8'h05));
            chk("t5_d2", 32'(wd_log[2]), 32'(8'h3C));
            chk("t5_d3", 32'(wd_log[3]), 32'(8'hFF));
            chk("t5_a3", 32'(wa_log[3]), 32'(3));
        end

        // 6: reset mid-DATA, then a clean frame
        fr = '{8'h05, 8'hA1, 8'hA2};
        send_frame(fr, 0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values();
        @(negedge clock);
        #2;
        reset = 1'b1;
        wa_log.delete(); wd_log.delete();
        fr = '{8'h02, 8'h40, 8'h41, 8'h7F};
        send_frame(fr, 0, 1'b0);
        wait_quiet();
        chk("t6_done", 32'(done), 32'(1));
        chk("t6_load_count", 32'(load_count), 32'(2));

        // Random frames
        for (int f = 0; f < 60; f++) begin
            fr.delete();
            kind = int'($urandom_range(0, 9));
            if (kind == 0) n = 0;
            else if (kind == 1) n = int'($urandom_range(17, 255));
            else n = int'($urandom_range(1, 16));
            fr.push_back(8'(n));
            if (n >= 1 && n <= 16) begin
                sum = 0;
                for (int i = 0; i < n; i++) begin
                    b = 8'($urandom);
                    fr.push_back(b);
                    sum += int'(b);
                end
                csum = 8'((256 - (sum % 256)) % 256);
                if ($urandom_range(0, 3) == 0) csum = csum + 8'($urandom_range(1, 255));
                fr.push_back(csum);
            end
            mode = int'($urandom_range(0, 3));
            wait_quiet();
            send_frame(fr, mode, 1'($urandom_range(0, 1)));
            wait_quiet();
            idle_cycles(int'($urandom_range(0, 6)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
